// File: rtl/rx_fsrc_sample_packer.sv
// Removes filler samples from the RX converter stream: drops samples whose keep bit is
// clear, compacts the survivors in order and repacks them into full output beats.
module rx_fsrc_sample_packer #(
  parameter int DATA_WIDTH = 256,
  parameter int NP         = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic                       counter_clr,
  input  logic                       s_axis_valid,
  output logic                       s_axis_ready,
  input  logic [DATA_WIDTH-1:0]      s_axis_data,
  input  logic [DATA_WIDTH/NP-1:0]   s_axis_keep,
  output logic                       m_axis_valid,
  input  logic                       m_axis_ready,
  output logic [DATA_WIDTH-1:0]      m_axis_data,
  output logic [31:0]                dropped_count
);

  localparam int N  = DATA_WIDTH / NP;
  localparam int FW = $clog2(2 * N) + 1;

  function automatic logic [FW-1:0] popcount(input logic [N-1:0] v);
    logic [FW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + FW'(v[i]);
    end
    return c;
  endfunction

  logic [NP-1:0]   buf_r [2*N];
  logic [FW-1:0]   fill_r;
  logic            m_valid_r;
  logic            en_prev_r;
  logic [31:0]     drop_cnt_r;

  logic            en_edge_s;
  logic            in_hs_s;
  logic            out_hs_s;
  logic [N-1:0]    mask_s;
  logic [NP-1:0]   buf_nxt_s [2*N];
  logic [FW-1:0]   fill_nxt_s;
  logic [FW-1:0]   wr_s;
  logic [FW-1:0]   drop_inc_s;
  logic [32:0]     cnt_sum_s;
  logic [31:0]     cnt_nxt_s;

  // Enable rising edge flushes partial samples and blocks both handshakes for that cycle.
  assign en_edge_s     = enable & ~en_prev_r;
  assign m_axis_valid  = m_valid_r & ~en_edge_s;
  assign s_axis_ready  = ~en_edge_s & (~m_valid_r | m_axis_ready);
  assign in_hs_s       = s_axis_valid & s_axis_ready;
  assign out_hs_s      = m_axis_valid & m_axis_ready;
  assign mask_s        = enable ? s_axis_keep : {N{1'b1}};
  assign dropped_count = drop_cnt_r;

  for (genvar g = 0; g < N; g++) begin : g_out
    assign m_axis_data[g*NP +: NP] = buf_r[g];
  end

  // Buffer update: output shift first, then append the compacted kept samples at fill'.
  always_comb begin
    buf_nxt_s  = buf_r;
    fill_nxt_s = fill_r;
    wr_s       = '0;
    if (en_edge_s) begin
      fill_nxt_s = '0;
      for (int i = 0; i < 2 * N; i++) begin
        buf_nxt_s[i] = '0;
      end
    end else begin
      if (out_hs_s) begin
        for (int i = 0; i < N; i++) begin
          buf_nxt_s[i] = buf_r[i+N];
        end
        for (int i = N; i < 2 * N; i++) begin
          buf_nxt_s[i] = '0;
        end
        fill_nxt_s = fill_r - FW'(N);
      end else begin
        fill_nxt_s = fill_r;
      end
      if (in_hs_s) begin
        wr_s = fill_nxt_s;
        for (int k = 0; k < N; k++) begin
          if (mask_s[k] && (wr_s < FW'(2 * N))) begin
            buf_nxt_s[wr_s[FW-2:0]] = s_axis_data[k*NP +: NP];
            wr_s = wr_s + FW'(1);
          end else begin
            wr_s = wr_s;
          end
        end
        fill_nxt_s = wr_s;
      end else begin
        wr_s = fill_nxt_s;
      end
    end
  end

  // Saturating dropped-sample counter; clear wins over a same-cycle increment.
  always_comb begin
    drop_inc_s = FW'(N) - popcount(s_axis_keep);
    cnt_sum_s  = {1'b0, drop_cnt_r} + 33'(drop_inc_s);
    if (counter_clr) begin
      cnt_nxt_s = 32'h0000_0000;
    end else if (in_hs_s && enable) begin
      cnt_nxt_s = cnt_sum_s[32] ? 32'hFFFF_FFFF : cnt_sum_s[31:0];
    end else begin
      cnt_nxt_s = drop_cnt_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 2 * N; i++) begin
        buf_r[i] <= '0;
      end
      fill_r     <= '0;
      m_valid_r  <= 1'b0;
      en_prev_r  <= 1'b0;
      drop_cnt_r <= 32'h0000_0000;
    end else begin
      buf_r      <= buf_nxt_s;
      fill_r     <= fill_nxt_s;
      m_valid_r  <= (fill_nxt_s >= FW'(N));
      en_prev_r  <= enable;
      drop_cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_rx_fsrc_sample_packer.sv
// Directed table-driven bench for rx_fsrc_sample_packer (N=16 samples of 16 bits).
module tb_rx_fsrc_sample_packer;

  logic         clk = 1'b0;
  logic         resetn;
  logic         enable;
  logic         counter_clr;
  logic         s_axis_valid;
  logic         s_axis_ready;
  logic [255:0] s_axis_data;
  logic [15:0]  s_axis_keep;
  logic         m_axis_valid;
  logic         m_axis_ready;
  logic [255:0] m_axis_data;
  logic [31:0]  dropped_count;

  int n_pass = 0;
  int n_total = 0;
  logic [255:0] obs_q[$];

  rx_fsrc_sample_packer #(.DATA_WIDTH(256), .NP(16)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .counter_clr(counter_clr),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_data(s_axis_data), .s_axis_keep(s_axis_keep),
    .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_data(m_axis_data), .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (resetn && m_axis_valid && m_axis_ready) obs_q.push_back(m_axis_data);
  end

  typedef struct {
    logic        en;
    logic        v;
    logic [15:0] keep;
    logic [15:0] base;
    logic        mr;
    logic        clr;
    logic        e_mv;
    logic        e_sr;
    logic [15:0] e_s0;
    logic [15:0] e_s15;
    logic [31:0] e_drop;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic en, input logic v, input logic [15:0] keep,
                       input logic [15:0] base, input logic mr, input logic clr);
    enable = en; s_axis_valid = v; s_axis_keep = keep;
    m_axis_ready = mr; counter_clr = clr;
    for (int k = 0; k < 16; k++) s_axis_data[k*16 +: 16] = base + 16'(k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] seq_beat(input logic [15:0] base);
    logic [255:0] b;
    for (int k = 0; k < 16; k++) b[k*16 +: 16] = base + 16'(k);
    return b;
  endfunction

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].keep, tbl[i].base, tbl[i].mr, tbl[i].clr);
      @(negedge clk);
      chk($sformatf("row%0d_mvalid", i), 256'(m_axis_valid), 256'(tbl[i].e_mv));
      chk($sformatf("row%0d_sready", i), 256'(s_axis_ready), 256'(tbl[i].e_sr));
      chk($sformatf("row%0d_dropped", i), 256'(dropped_count), 256'(tbl[i].e_drop));
      if (tbl[i].e_mv) begin
        chk($sformatf("row%0d_s0", i), 256'(m_axis_data[15:0]), 256'(tbl[i].e_s0));
        chk($sformatf("row%0d_s15", i), 256'(m_axis_data[255:240]), 256'(tbl[i].e_s15));
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [255:0] exp_b;
    int idx;

    // Bypass: 4 full beats of 0..63, keep ignored.
    tbl[0]  = '{1'b0, 1'b1, 16'h0000, 16'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'd0,  16'd0,  32'd0};
    tbl[1]  = '{1'b0, 1'b1, 16'h0000, 16'd16, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0,  16'd15, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 16'h0000, 16'd32, 1'b1, 1'b0, 1'b1, 1'b1, 16'd16, 16'd31, 32'd0};
    tbl[3]  = '{1'b0, 1'b1, 16'h0000, 16'd48, 1'b1, 1'b0, 1'b1, 1'b1, 16'd32, 16'd47, 32'd0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 16'd0,  1'b1, 1'b0, 1'b1, 1'b1, 16'd48, 16'd63, 32'd0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 16'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'd0,  16'd0,  32'd0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0,  32'd0};
    // Simultaneous in/out starting from fill=15 holding 301..315.
    tbl[7]  = '{1'b1, 1'b1, 16'h001F, 16'd400, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,   16'd0,   32'd17};
    tbl[8]  = '{1'b1, 1'b1, 16'h00FF, 16'd500, 1'b1, 1'b0, 1'b1, 1'b1, 16'd301, 16'd400, 32'd28};
    tbl[9]  = '{1'b1, 1'b1, 16'h000F, 16'd600, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,   16'd0,   32'd36};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 16'd0,   1'b1, 1'b0, 1'b1, 1'b1, 16'd401, 16'd603, 32'd48};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 16'd0,   1'b1, 1'b0, 1'b0, 1'b1, 16'd0,   16'd0,   32'd48};
    // Counter saturation and clear priority, counter preset to FFFFFFF0.
    tbl[12] = '{1'b1, 1'b1, 16'h0000, 16'd1000, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 32'hFFFF_FFF0};
    tbl[13] = '{1'b1, 1'b1, 16'h0000, 16'd1000, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 32'hFFFF_FFFF};
    tbl[14] = '{1'b1, 1'b1, 16'h007F, 16'd1100, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 32'hFFFF_FFFF};
    tbl[15] = '{1'b1, 1'b0, 16'h0000, 16'd0,    1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 32'd0};

    resetn = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b0);
    tick();
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_mvalid", 256'(m_axis_valid), 256'(1'b0));
    chk("reset_sready", 256'(s_axis_ready), 256'(1'b1));
    chk("reset_data", m_axis_data, 256'd0);
    chk("reset_dropped", 256'(dropped_count), 256'd0);
    @(posedge clk);
    #1;

    run_rows(0, 6);

    // Drop sample 0 of each of 16 beats: 240 kept samples -> 15 output beats.
    obs_q.delete();
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 1'b1, 16'hFFFE, 16'(16 * j), 1'b1, 1'b0);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b0, 16'h0000, 16'd0, 1'b1, 1'b0);
      tick();
    end
    chk("drop_beats", 256'(obs_q.size()), 256'd15);
    for (int b = 0; b < 15 && b < obs_q.size(); b++) begin
      for (int i = 0; i < 16; i++) begin
        idx = 16 * b + i;
        exp_b[i*16 +: 16] = 16'(16 * (idx / 15) + (idx % 15) + 1);
      end
      chk($sformatf("drop_beat%0d", b), obs_q[b], exp_b);
    end
    chk("drop_count16", 256'(dropped_count), 256'd16);

    // Backpressure: fill=15, then a full beat with m_axis_ready low.
    drive(1'b1, 1'b1, 16'h7FFF, 16'd100, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_pre_mvalid", 256'(m_axis_valid), 256'(1'b0));
    tick();
    drive(1'b1, 1'b1, 16'hFFFF, 16'd200, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_fill15_sready", 256'(s_axis_ready), 256'(1'b1));
    tick();
    for (int k = 0; k < 15; k++) exp_b[k*16 +: 16] = 16'(100 + k);
    exp_b[255:240] = 16'd200;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b1, 16'hFFFF, 16'd300, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("bp_stall%0d_mvalid", c), 256'(m_axis_valid), 256'(1'b1));
      chk($sformatf("bp_stall%0d_sready", c), 256'(s_axis_ready), 256'(1'b0));
      chk($sformatf("bp_stall%0d_data", c), m_axis_data, exp_b);
      tick();
    end
    drive(1'b1, 1'b1, 16'hFFFF, 16'd300, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_resume_sready", 256'(s_axis_ready), 256'(1'b1));
    chk("bp_resume_data", m_axis_data, exp_b);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 16'd0, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) exp_b[k*16 +: 16] = 16'(201 + k);
    exp_b[255:240] = 16'd300;
    @(negedge clk);
    chk("bp_next_mvalid", 256'(m_axis_valid), 256'(1'b1));
    chk("bp_next_data", m_axis_data, exp_b);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_left15_mvalid", 256'(m_axis_valid), 256'(1'b0));
    tick();

    run_rows(7, 11);

    force dut.drop_cnt_r = 32'hFFFF_FFF0;
    #1;
    release dut.drop_cnt_r;
    run_rows(12, 15);

    // Reset mid-stream with fill=7, enable low so the first cycle after reset is not an edge.
    resetn = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b0);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("rst2_mvalid", 256'(m_axis_valid), 256'(1'b0));
    chk("rst2_sready", 256'(s_axis_ready), 256'(1'b1));
    chk("rst2_data", m_axis_data, 256'd0);
    chk("rst2_dropped", 256'(dropped_count), 256'd0);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("edge1_sready", 256'(s_axis_ready), 256'(1'b0));
    tick();
    drive(1'b1, 1'b1, 16'h001F, 16'd900, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_edge1_sready", 256'(s_axis_ready), 256'(1'b1));
    tick();
    drive(1'b1, 1'b1, 16'hFFFF, 16'd950, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 16'd0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) exp_b[k*16 +: 16] = 16'(900 + k);
    for (int k = 5; k < 16; k++) exp_b[k*16 +: 16] = 16'(950 + k - 5);
    @(negedge clk);
    chk("rst2_discard_data", m_axis_data, exp_b);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("edge2_sready", 256'(s_axis_ready), 256'(1'b0));
    chk("edge2_mvalid", 256'(m_axis_valid), 256'(1'b0));
    tick();
    drive(1'b1, 1'b1, 16'hFFFF, 16'd700, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_edge2_sready", 256'(s_axis_ready), 256'(1'b1));
    tick();
    drive(1'b1, 1'b0, 16'h0000, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("edge2_flush_mvalid", 256'(m_axis_valid), 256'(1'b1));
    chk("edge2_flush_data", m_axis_data, seq_beat(16'd700));
    tick();
    drive(1'b1, 1'b0, 16'h0000, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("final_mvalid", 256'(m_axis_valid), 256'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
